sap_out_port: RTL and testbench

- Downstream consumer of the SAP-1 OUT stage.
- Captures each byte the processor outputs, on the same clock edge and with the same active-low load strobe that loads the output register.
- Buffers captured bytes in a small FIFO and presents them to an external host over a valid/ready handshake. A slow host therefore never loses results.
- Reports overflow and a saturating drop count when the host falls behind.

---
 rtl/sap_out_port.sv | 167 ++++++++++++++++
 tb/tb_sap_out_port.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sap_out_port.sv
// sap_out_port: captures every byte the SAP-1 OUT stage loads (lo_n low at a
// rising clk edge) into a small FIFO and hands the bytes to a host over a
// valid/ready handshake. Overflow is sticky, and the drop count saturates at 15.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   lo_n, out_in      output-load strobe (active low) and accumulator byte
//   m_valid, m_ready  host handshake; m_data is the head entry (0 when empty)
//   count, full,      occupancy (0..DEPTH) and its derived flags
//   empty
//   overflow,         sticky dropped-push flag and saturating drop count
//   drop_cnt
//   clr_ovf           one-cycle pulse that clears overflow and drop_cnt
//   m_parity          even parity of m_data (only with SAP_OUT_PORT_PARITY_EN)
//
// Optional feature macro: SAP_OUT_PORT_PARITY_EN adds a stored parity bit per
// entry and the m_parity output.
module sap_out_port #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lo_n,
    input  logic [DATA_W-1:0] out_in,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic [3:0]        drop_cnt,
`ifdef SAP_OUT_PORT_PARITY_EN
    output logic              m_parity,
`endif
    input  logic              clr_ovf
);

    localparam int unsigned CNT_W = PTR_W + 1;
`ifdef SAP_OUT_PORT_PARITY_EN
    localparam int unsigned PAR_W = 1;
`else
    localparam int unsigned PAR_W = 0;
`endif
    localparam int unsigned ENTRY_W = DATA_W + PAR_W;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e               state_q;
    logic [ENTRY_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 full_q, empty_q;
    logic [ENTRY_W-1:0]   head_q, head_d;
    logic                 ovf_q, ovf_d;
    logic [3:0]           drop_q, drop_d;
    logic [ENTRY_W-1:0]   entry_in;
    logic                 push, pop, wr_en, drop;

    // Entry as stored: optional even-parity bit above the data byte.
`ifdef SAP_OUT_PORT_PARITY_EN
    assign entry_in = {^out_in, out_in};
`else
    assign entry_in = out_in;
`endif

    // Handshake decode; a push while full is only accepted if a pop frees a slot.
    always_comb begin
        push  = !lo_n;
        pop   = (state_q == HOLD) && m_ready;
        wr_en = push && (!full_q || pop);
        drop  = push && full_q && !pop;
    end

    // Next pointers, occupancy and head-of-queue value.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        head_d  = '0;
        if (wr_en) wptr_d = wptr_q + PTR_W'(1);
        if (pop)   rptr_d = rptr_q + PTR_W'(1);
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        // The new head may be the byte being written this edge.
        if (count_d != '0) begin
            if (wr_en && (wptr_q == rptr_d)) head_d = entry_in;
            else                             head_d = mem_q[rptr_d];
        end
    end

    // Overflow bookkeeping; a drop in the clearing cycle restarts the count at 1.
    always_comb begin
        ovf_d  = ovf_q;
        drop_d = drop_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (clr_ovf)              drop_d = 4'd1;
            else if (drop_q != 4'd15) drop_d = drop_q + 4'd1;
        end else if (clr_ovf) begin
            ovf_d  = 1'b0;
            drop_d = 4'd0;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem_q[wptr_q] <= entry_in;
    end

    // Pointers, occupancy flags, registered head and overflow state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            head_q  <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= 4'd0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            full_q  <= (count_d == CNT_W'(DEPTH));
            empty_q <= (count_d == '0);
            head_q  <= head_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // Host-side control FSM: HOLD whenever the FIFO has something to offer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (wr_en) state_q <= HOLD;
                HOLD:    if (pop && !wr_en && (count_q == CNT_W'(1))) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_valid  = (state_q == HOLD);
    assign m_data   = head_q[DATA_W-1:0];
`ifdef SAP_OUT_PORT_PARITY_EN
    assign m_parity = head_q[DATA_W];
`endif
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign overflow = ovf_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_sap_out_port.sv
// Directed self-checking bench for sap_out_port.
module tb_sap_out_port;

    logic       clk = 1'b0;
    logic       rst;
    logic       lo_n;
    logic [7:0] out_in;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] m_data;
    logic [2:0] count;
    logic       full;
    logic       empty;
    logic       overflow;
    logic [3:0] drop_cnt;
    logic       clr_ovf;
`ifdef SAP_OUT_PORT_PARITY_EN
    logic       m_parity;
`endif

    int checks = 0;
    int errors = 0;

    sap_out_port dut (
        .clk      (clk),
        .rst      (rst),
        .lo_n     (lo_n),
        .out_in   (out_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .drop_cnt (drop_cnt),
`ifdef SAP_OUT_PORT_PARITY_EN
        .m_parity (m_parity),
`endif
        .clr_ovf  (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; lo_n = 1'b0; out_in = 8'h55; m_ready = 1'b0; clr_ovf = 1'b0;
        tick(); tick();
        checks++; if (count !== 3'd0)     begin errors++; $display("FAIL reset_count got %0d want 0", count); end
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL reset_empty got %b want 1", empty); end
        checks++; if (full !== 1'b0)      begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (m_valid !== 1'b0)   begin errors++; $display("FAIL reset_valid got %b want 0", m_valid); end
        checks++; if (m_data !== 8'h00)   begin errors++; $display("FAIL reset_data got %h want 00", m_data); end
        checks++; if (overflow !== 1'b0)  begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
        checks++; if (drop_cnt !== 4'd0)  begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
        rst = 1'b0; lo_n = 1'b1;
    endtask

    task automatic test_single_stall_pop();
        lo_n = 1'b0; out_in = 8'h03; m_ready = 1'b0;
        tick();
        lo_n = 1'b1; out_in = 8'hFF;
        checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", m_valid); end
        checks++; if (m_data !== 8'h03) begin errors++; $display("FAIL single_data got %h want 03", m_data); end
        checks++; if (count !== 3'd1)   begin errors++; $display("FAIL single_count got %0d want 1", count); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (m_valid !== 1'b1 || m_data !== 8'h03)
                begin errors++; $display("FAIL stall_stable cyc %0d got v=%b d=%h want v=1 d=03", i, m_valid, m_data); end
        end
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        checks++; if (empty !== 1'b1)   begin errors++; $display("FAIL pop_empty got %b want 1", empty); end
        checks++; if (m_data !== 8'h00) begin errors++; $display("FAIL pop_data got %h want 00", m_data); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL pop_valid got %b want 0", m_valid); end
    endtask

    task automatic fill4();
        m_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            lo_n = 1'b0; out_in = 8'(i);
            tick();
        end
        lo_n = 1'b1;
    endtask

    task automatic test_fill_drop();
        logic [7:0] exp [4];
        exp[0] = 8'h01; exp[1] = 8'h02; exp[2] = 8'h03; exp[3] = 8'h04;
        fill4();
        checks++; if (full !== 1'b1)  begin errors++; $display("FAIL fill_full got %b want 1", full); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d want 4", count); end
        lo_n = 1'b0; out_in = 8'h05;
        tick();
        lo_n = 1'b1;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL drop_ovf got %b want 1", overflow); end
        checks++; if (drop_cnt !== 4'd1) begin errors++; $display("FAIL drop_cnt got %0d want 1", drop_cnt); end
        checks++; if (count !== 3'd4)    begin errors++; $display("FAIL drop_count got %0d want 4", count); end
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp[i])
                begin errors++; $display("FAIL drain1 idx %0d got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, exp[i]); end
            tick();
        end
        m_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain1_empty got %b want 1", empty); end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0 || drop_cnt !== 4'd0)
            begin errors++; $display("FAIL clr1 got ovf=%b cnt=%0d want 0 0", overflow, drop_cnt); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp [4];
        exp[0] = 8'h02; exp[1] = 8'h03; exp[2] = 8'h04; exp[3] = 8'hAA;
        fill4();
        lo_n = 1'b0; out_in = 8'hAA; m_ready = 1'b1;
        tick();
        lo_n = 1'b1;
        checks++; if (count !== 3'd4)    begin errors++; $display("FAIL fpp_count got %0d want 4", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %b want 0", overflow); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (m_valid !== 1'b1 || m_data !== exp[i])
                begin errors++; $display("FAIL drain2 idx %0d got v=%b d=%h want v=1 d=%h", i, m_valid, m_data, exp[i]); end
            tick();
        end
        m_ready = 1'b0;
        checks++; if (empty !== 1'b1 || count !== 3'd0)
            begin errors++; $display("FAIL drain2_empty got e=%b c=%0d want 1 0", empty, count); end
    endtask

    task automatic test_saturation_clear();
        fill4();
        lo_n = 1'b0; out_in = 8'h77;
        for (int i = 0; i < 20; i++) tick();
        lo_n = 1'b1;
        checks++; if (drop_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt got %0d want 15", drop_cnt); end
        checks++; if (overflow !== 1'b1)  begin errors++; $display("FAIL sat_ovf got %b want 1", overflow); end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0 || drop_cnt !== 4'd0)
            begin errors++; $display("FAIL clr2 got ovf=%b cnt=%0d want 0 0", overflow, drop_cnt); end
        clr_ovf = 1'b1; lo_n = 1'b0; out_in = 8'h88;
        tick();
        clr_ovf = 1'b0; lo_n = 1'b1;
        checks++; if (overflow !== 1'b1 || drop_cnt !== 4'd1)
            begin errors++; $display("FAIL clr_vs_drop got ovf=%b cnt=%0d want 1 1", overflow, drop_cnt); end
        checks++; if (m_data !== 8'h01) begin errors++; $display("FAIL sat_head got %h want 01", m_data); end
        clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        m_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sat_drain got %b want 1", empty); end
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            lo_n = 1'b0; out_in = 8'h10 + 8'(i);
            tick();
        end
        lo_n = 1'b1;
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_count got %0d want 3", count); end
        rst = 1'b1; lo_n = 1'b0; m_ready = 1'b1; out_in = 8'h99;
        tick();
        rst = 1'b0; lo_n = 1'b1; m_ready = 1'b0;
        checks++; if (count !== 3'd0 || empty !== 1'b1)
            begin errors++; $display("FAIL mid_rst got c=%0d e=%b want 0 1", count, empty); end
        checks++; if (m_valid !== 1'b0 || m_data !== 8'h00)
            begin errors++; $display("FAIL mid_rst_out got v=%b d=%h want 0 00", m_valid, m_data); end
        tick();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_quiet got %b want 0", m_valid); end
    endtask

`ifdef SAP_OUT_PORT_PARITY_EN
    task automatic test_parity();
        lo_n = 1'b0; out_in = 8'h07; m_ready = 1'b0;
        tick();
        lo_n = 1'b0; out_in = 8'h03;
        tick();
        lo_n = 1'b1;
        checks++; if (m_data !== 8'h07 || m_parity !== 1'b1)
            begin errors++; $display("FAIL par_07 got d=%h p=%b want 07 1", m_data, m_parity); end
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        checks++; if (m_data !== 8'h03 || m_parity !== 1'b0)
            begin errors++; $display("FAIL par_03 got d=%h p=%b want 03 0", m_data, m_parity); end
        m_ready = 1'b1; tick(); m_ready = 1'b0;
        checks++; if (m_parity !== 1'b0) begin errors++; $display("FAIL par_empty got %b want 0", m_parity); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_stall_pop();
        test_fill_drop();
        test_full_push_pop();
        test_saturation_clear();
        test_reset_mid();
`ifdef SAP_OUT_PORT_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
